// File: rtl/ctrl_pipe_if.sv
// Bus between the ID-stage decoder and the pipeline control block.
// The master drives decoder fields and the MEM zero flag; the slave returns stage controls.
interface ctrl_pipe_if;
  logic [8:0] id_ctrl;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  logic       mem_zero;

  logic       ex_regdst;
  logic [1:0] ex_aluop;
  logic       ex_alusrc;
  logic       mem_branch;
  logic       mem_memread;
  logic       mem_memwrite;
  logic       wb_regwrite;
  logic       wb_memtoreg;
  logic [4:0] wb_dst;
  logic       stall;
  logic       pcsrc;
  logic       if_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    output id_ctrl, id_rs, id_rt, id_rd, mem_zero,
    input  ex_regdst, ex_aluop, ex_alusrc,
    input  mem_branch, mem_memread, mem_memwrite,
    input  wb_regwrite, wb_memtoreg, wb_dst,
    input  stall, pcsrc, if_flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_ctrl, id_rs, id_rt, id_rd, mem_zero,
    output ex_regdst, ex_aluop, ex_alusrc,
    output mem_branch, mem_memread, mem_memwrite,
    output wb_regwrite, wb_memtoreg, wb_dst,
    output stall, pcsrc, if_flush, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control path of a 5-stage MIPS-style pipeline: ID/EX, EX/MEM and MEM/WB control registers
// with load-use bubble insertion, branch flush and EX-stage operand forwarding selects.
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
);

  logic [8:0] idex_ctrl;
  logic [4:0] idex_rs;
  logic [4:0] idex_rt;
  logic [4:0] idex_rd;

  // EX/MEM keeps id_ctrl[8:4]: [4]RegWrite [3]MemtoReg [2]Branch [1]MemRead [0]MemWrite
  logic [4:0] exmem_ctrl;
  logic [4:0] exmem_dst;

  // MEM/WB keeps [1]RegWrite [0]MemtoReg
  logic [1:0] memwb_ctrl;
  logic [4:0] memwb_dst;

  logic [4:0] ex_dst;
  logic       load_use;
  logic       pcsrc;
  logic       stall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       em_rw,
    input logic [4:0] em_dst,
    input logic       mw_rw,
    input logic [4:0] mw_dst
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (em_rw && (em_dst != 5'd0) && (em_dst == src))
      sel = 2'b10;
    else if (mw_rw && (mw_dst != 5'd0) && (mw_dst == src))
      sel = 2'b01;
    return sel;
  endfunction

  assign ex_dst   = idex_ctrl[3] ? idex_rd : idex_rt;
  assign pcsrc    = exmem_ctrl[2] & bus.mem_zero;
  assign load_use = idex_ctrl[5] & ((idex_rt == bus.id_rs) | (idex_rt == bus.id_rt));
  // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
  assign stall    = load_use & ~pcsrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl  <= '0;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_rd    <= '0;
      exmem_ctrl <= '0;
      exmem_dst  <= '0;
      memwb_ctrl <= '0;
      memwb_dst  <= '0;
    end else begin
      idex_ctrl  <= (stall | pcsrc) ? 9'd0 : bus.id_ctrl;
      idex_rs    <= bus.id_rs;
      idex_rt    <= bus.id_rt;
      idex_rd    <= bus.id_rd;
      exmem_ctrl <= pcsrc ? 5'd0 : idex_ctrl[8:4];
      exmem_dst  <= ex_dst;
      memwb_ctrl <= exmem_ctrl[4:3];
      memwb_dst  <= exmem_dst;
    end
  end

  assign bus.ex_regdst    = idex_ctrl[3];
  assign bus.ex_aluop     = idex_ctrl[2:1];
  assign bus.ex_alusrc    = idex_ctrl[0];
  assign bus.mem_branch   = exmem_ctrl[2];
  assign bus.mem_memread  = exmem_ctrl[1];
  assign bus.mem_memwrite = exmem_ctrl[0];
  assign bus.wb_regwrite  = memwb_ctrl[1];
  assign bus.wb_memtoreg  = memwb_ctrl[0];
  assign bus.wb_dst       = memwb_dst;
  assign bus.stall        = stall;
  assign bus.pcsrc        = pcsrc;
  assign bus.if_flush     = pcsrc;
  assign bus.fwd_a        = fwd_sel(idex_rs, exmem_ctrl[4], exmem_dst, memwb_ctrl[1], memwb_dst);
  assign bus.fwd_b        = fwd_sel(idex_rt, exmem_ctrl[4], exmem_dst, memwb_ctrl[1], memwb_dst);

endmodule
